// File: rtl/serial_reg_master_if.sv
// Host byte stream and register bus seen by serial_reg_master.
// master: the bus initiator; slave: host FIFO plus register slaves.
interface serial_reg_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  reg_cmd;
    logic [15:0] reg_bytecount;
    logic [7:0]  reg_data_in;
    logic [7:0]  reg_data_out;
    logic        reg_read;
    logic        reg_write;

    modport master (
        input  rx_data, rx_valid, tx_ready, reg_data_out,
        output rx_ready, tx_data, tx_valid,
        output reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, reg_data_out,
        input  rx_ready, tx_data, tx_valid,
        input  reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write
    );
endinterface

// File: rtl/serial_reg_master.sv
// Register-bus initiator decoding HDR/LEN_LO/LEN_HI/payload host packets.
// Define SERIAL_REG_TIMEOUT_EN to abort stalled packets and flag err_timeout.
module serial_reg_master #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_200_000
) (
    input  logic                  clk_usb,
    input  logic                  reset_n,
    serial_reg_master_if.master   bus,
    output logic                  busy,
    output logic                  err_timeout
);
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, WRITE, RD_CAP, RD_SEND
    } state_t;

    state_t      state, state_nx;
    logic        rd_dir;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] rx_left;
    logic [15:0] len_nx;
    logic        rx_acc;
    logic        tx_acc;
    logic        last_idx;
    logic        timeout;

    assign rx_acc   = bus.rx_valid && bus.rx_ready;
    assign tx_acc   = bus.tx_valid && bus.tx_ready;
    assign len_nx   = {bus.rx_data, len_lo};
    assign last_idx = (bus.reg_bytecount == len - 16'd1);

`ifdef SERIAL_REG_TIMEOUT_EN
    logic [23:0] idle_cnt;
    logic        timed;

    assign timed   = state inside {LEN_LO, LEN_HI, WRITE};
    assign timeout = timed && !rx_acc &&
                     (idle_cnt == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (!timed || rx_acc || timeout)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 24'd1;
            if (timeout)
                err_timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    always_ff @(posedge clk_usb) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (timeout) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (rx_acc) state_nx = LEN_LO;
                LEN_LO:  if (rx_acc) state_nx = LEN_HI;
                LEN_HI:
                    if (rx_acc) begin
                        if (len_nx == 16'd0) state_nx = IDLE;
                        else if (rd_dir)     state_nx = RD_CAP;
                        else                 state_nx = WRITE;
                    end
                // leave only once the final byte's strobe has been shown
                WRITE:   if (bus.reg_write && last_idx) state_nx = IDLE;
                RD_CAP:  state_nx = RD_SEND;
                RD_SEND:
                    if (tx_acc) state_nx = last_idx ? IDLE : RD_CAP;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rx_ready = 1'b0;
        bus.tx_valid = 1'b0;
        bus.reg_read = 1'b0;
        busy         = (state != IDLE);
        unique case (state)
            IDLE, LEN_LO, LEN_HI: bus.rx_ready = 1'b1;
            WRITE:   bus.rx_ready = (rx_left != 16'd0);
            RD_CAP:  bus.reg_read = 1'b1;
            RD_SEND: bus.tx_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            bus.reg_cmd       <= '0;
            bus.reg_bytecount <= '0;
            bus.reg_data_in   <= '0;
            bus.reg_write     <= 1'b0;
            bus.tx_data       <= '0;
            rd_dir            <= 1'b0;
            len_lo            <= '0;
            len               <= '0;
            rx_left           <= '0;
        end else begin
            bus.reg_write <= 1'b0;
            unique case (state)
                IDLE:
                    if (rx_acc) begin
                        bus.reg_cmd <= {1'b0, bus.rx_data[6:0]};
                        rd_dir      <= bus.rx_data[7];
                    end
                LEN_LO:
                    if (rx_acc) len_lo <= bus.rx_data;
                LEN_HI:
                    if (rx_acc) begin
                        len               <= len_nx;
                        rx_left           <= len_nx;
                        bus.reg_bytecount <= '0;
                    end
                WRITE: begin
                    if (rx_acc) begin
                        bus.reg_data_in <= bus.rx_data;
                        bus.reg_write   <= 1'b1;
                        rx_left         <= rx_left - 16'd1;
                    end
                    if (bus.reg_write)
                        bus.reg_bytecount <= bus.reg_bytecount + 16'd1;
                end
                RD_CAP:
                    bus.tx_data <= bus.reg_data_out;
                RD_SEND:
                    if (tx_acc)
                        bus.reg_bytecount <= bus.reg_bytecount + 16'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_reg_master.sv
// Directed bench for serial_reg_master: packet-level expectation queues
// checked every cycle, plus literal spot checks.
module tb_serial_reg_master;
    logic clk_usb = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    logic err_timeout;

    serial_reg_master_if bus();

    serial_reg_master #(.TIMEOUT_CYCLES(24'd100)) dut (
        .clk_usb     (clk_usb),
        .reset_n     (reset_n),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk_usb = ~clk_usb;

    // slave at address 0x05 returns 0x10 + index; others read as zero
    assign bus.reg_data_out = (bus.reg_cmd == 8'h05) ?
        8'h10 + bus.reg_bytecount[7:0] : 8'h00;

    int vectors = 0;
    int errors  = 0;
    int n_wr    = 0;
    int n_rd    = 0;

    logic [31:0] exp_wr[$];
    logic [23:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  wd[$];
    logic        hold_q = 1'b0;
    logic [7:0]  hold_d = 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_usb) begin
        if (!reset_n) begin
            hold_q = 1'b0;
        end else begin
            if (bus.reg_write) begin
                n_wr++;
                check("wr_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0)
                    check("wr_event", {bus.reg_cmd, bus.reg_bytecount,
                          bus.reg_data_in}, exp_wr.pop_front());
            end
            if (bus.reg_read) begin
                n_rd++;
                check("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0)
                    check("rd_event", {8'h00, bus.reg_cmd,
                          bus.reg_bytecount}, {8'h00, exp_rd.pop_front()});
                check("rd_no_wr", bus.reg_write, 0);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                check("tx_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0)
                    check("tx_byte", bus.tx_data, exp_tx.pop_front());
            end
            if (bus.reg_read || bus.tx_valid)
                check("rx_ready_in_read", bus.rx_ready, 0);
            if (hold_q) begin
                check("tx_hold_valid", bus.tx_valid, 1);
                check("tx_hold_data", bus.tx_data, hold_d);
            end
            hold_q = bus.tx_valid && !bus.tx_ready;
            hold_d = bus.tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && t < 200) begin
            @(posedge clk_usb); #1;
            t++;
        end
        if (t >= 200) check("rx_accept_timeout", t, 0);
        @(posedge clk_usb); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic packet(input logic [7:0] hdr, input logic [15:0] n,
                          input int gap);
        for (int k = 0; k < int'(n); k++) begin
            if (hdr[7]) begin
                exp_rd.push_back({1'b0, hdr[6:0], 16'(k)});
                exp_tx.push_back(hdr[6:0] == 7'h05 ?
                                 8'h10 + 8'(k) : 8'h00);
            end else begin
                exp_wr.push_back({1'b0, hdr[6:0], 16'(k), wd[k]});
            end
        end
        send_byte(hdr);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        if (!hdr[7]) begin
            foreach (wd[i]) begin
                send_byte(wd[i]);
                repeat (gap) begin @(posedge clk_usb); #1; end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy && t < budget) begin
            @(posedge clk_usb); #1;
            t++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic wait_tx(input int budget);
        int t = 0;
        while (!bus.tx_valid && t < budget) begin
            @(posedge clk_usb); #1;
            t++;
        end
        check("tx_valid_reached", bus.tx_valid, 1);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (3) @(posedge clk_usb);
        #1 reset_n = 1'b1;

        check("rst_rx_ready", bus.rx_ready, 1);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_reg_read", bus.reg_read, 0);
        check("rst_reg_write", bus.reg_write, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd", bus.reg_cmd, 8'h00);
        check("rst_bc", bus.reg_bytecount, 16'h0000);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_din", bus.reg_data_in, 8'h00);
        check("rst_err", err_timeout, 0);

        wd = '{8'hAA, 8'hBB};
        packet(8'h05, 16'd2, 0);
        wait_idle(50);
        check("wr2_count", n_wr, 2);
        check("wr2_cmd", bus.reg_cmd, 8'h05);
        check("wr2_last_din", bus.reg_data_in, 8'hBB);

        wd.delete();
        packet(8'h85, 16'd2, 0);
        wait_idle(50);
        check("rd2_count", n_rd, 2);
        check("rd2_last_tx", bus.tx_data, 8'h11);

        bus.tx_ready = 1'b0;
        packet(8'h85, 16'd1, 0);
        wait_tx(20);
        repeat (20) begin @(posedge clk_usb); #1; end
        check("hold_valid", bus.tx_valid, 1);
        check("hold_data", bus.tx_data, 8'h10);
        check("hold_busy", busy, 1);
        check("hold_rd_count", n_rd, 3);
        bus.tx_ready = 1'b1;
        wait_idle(10);
        check("hold_rd_final", n_rd, 3);

        packet(8'h12, 16'd0, 0);
        check("zero_wr_idle", busy, 0);
        packet(8'h92, 16'd0, 0);
        check("zero_rd_idle", busy, 0);
        repeat (5) begin @(posedge clk_usb); #1; end
        check("zero_tx_valid", bus.tx_valid, 0);

        packet(8'hC3, 16'd3, 0);
        wait_idle(50);
        check("unk_cmd", bus.reg_cmd, 8'h43);
        check("unk_tx", bus.tx_data, 8'h00);
        check("unk_rd_count", n_rd, 6);

        wd = '{8'h01, 8'h02, 8'h03, 8'h04};
        packet(8'h7F, 16'd4, 3);
        wait_idle(50);
        check("gap_wr_count", n_wr, 6);

        exp_wr.push_back({8'h07, 16'd0, 8'h11});
        send_byte(8'h07);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        @(posedge clk_usb); #1;
        reset_n = 1'b0;
        @(posedge clk_usb); #1;
        reset_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_rx_ready", bus.rx_ready, 1);
        check("abort_cmd", bus.reg_cmd, 8'h00);
        check("abort_bc", bus.reg_bytecount, 16'h0000);
        repeat (5) begin @(posedge clk_usb); #1; end
        check("abort_wr_count", n_wr, 7);

        wd = '{8'h5A};
        packet(8'h21, 16'd1, 0);
        wait_idle(20);
        check("post_cmd", bus.reg_cmd, 8'h21);
        check("post_din", bus.reg_data_in, 8'h5A);
        check("post_wr_count", n_wr, 8);

        wd.delete();
        send_byte(8'h05);
        send_byte(8'h01);
        repeat (100) begin @(posedge clk_usb); #1; end
`ifdef SERIAL_REG_TIMEOUT_EN
        check("to_busy", busy, 0);
        check("to_err", err_timeout, 1);
`else
        check("to_busy", busy, 1);
        check("to_err", err_timeout, 0);
`endif
        reset_n = 1'b0;
        @(posedge clk_usb); #1;
        reset_n = 1'b1;
        check("end_err", err_timeout, 0);
        check("end_busy", busy, 0);

        check("left_wr", exp_wr.size(), 0);
        check("left_rd", exp_rd.size(), 0);
        check("left_tx", exp_tx.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
